// File: rtl/axis_hp_writer.sv
// rtl/axis_hp_writer.sv - AXI4-Stream to AXI4 INCR-burst write master for the PS HP port
//
// Purpose:
//   Buffers stream words in a local FIFO and writes them to DDR as INCR bursts of
//   up to BURST_LEN beats, with only one burst in flight at a time.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   cfg_start            start pulse (sampled only while idle and not busy)
//   cfg_base_addr        DDR byte address of the first beat
//   cfg_beats            total beats to write (0 completes immediately)
//   sts_busy/done/error  status: busy level, done pulse, sticky bad-BRESP flag
//   s_axis_*             input stream (tdata/tvalid/tready)
//   m_axi_aw*/w*/b*      AXI4 write address, data and response channels
//
// Build option:
//   AXIS_HP_WRITER_4K_SPLIT_EN  clip bursts at 4 KB boundaries and accept any
//                               beat-aligned base address.

module axis_hp_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cfg_start,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]    cfg_beats,
  output logic                    sts_busy,
  output logic                    sts_done,
  output logic                    sts_error,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [3:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

`ifdef AXIS_HP_WRITER_4K_SPLIT_EN
  // Only beat alignment is required; bursts are clipped at 4 KB instead.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
`else
  // Full-burst alignment guarantees no burst can straddle a 4 KB boundary.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BURST_LEN * BYTES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  r_awvalid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_total;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_accepted;
  logic [4:0]            r_burst_beats;
  logic [4:0]            r_beat_cnt;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_full;
  logic                  w_tready;
  logic                  w_push;
  logic                  w_wvalid;
  logic                  w_wlast;
  logic                  w_pop;
  logic [LEN_WIDTH-1:0]  w_remaining;
  logic [4:0]            w_rem_clip;
  logic [4:0]            w_burst_beats;
  logic                  w_burst_ready;

  // ------------------------------------------------------------------
  // Stream side and FIFO status
  // ------------------------------------------------------------------
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  // Words beyond the programmed count are held off rather than dropped.
  assign w_tready = r_busy & ~w_full & (r_accepted < r_total);
  assign w_push   = s_axis_tvalid & w_tready;

  assign w_wvalid = (r_state == S_DATA) & (r_count != '0);
  assign w_wlast  = (r_beat_cnt == (r_burst_beats - 5'd1));
  assign w_pop    = w_wvalid & m_axi_wready;

  // ------------------------------------------------------------------
  // Next burst size
  // ------------------------------------------------------------------
  assign w_remaining = r_total - r_issued;
  assign w_rem_clip  = (w_remaining >= LEN_WIDTH'(BURST_LEN)) ? 5'(BURST_LEN)
                                                              : w_remaining[4:0];

`ifdef AXIS_HP_WRITER_4K_SPLIT_EN
  logic [12:0] w_4k_room;
  // Beats left before the next 4 KB boundary; never zero for an aligned address.
  assign w_4k_room     = (13'd4096 - {1'b0, r_addr[11:0]}) >> SIZE;
  assign w_burst_beats = ({8'd0, w_rem_clip} > w_4k_room) ? w_4k_room[4:0] : w_rem_clip;
`else
  assign w_burst_beats = w_rem_clip;
`endif

  // A burst is only launched once every beat of it is already buffered, so the
  // W channel never stalls on an empty FIFO mid-burst.
  assign w_burst_ready = (w_remaining != '0) &&
                         (32'(r_count) >= 32'(w_burst_beats));

  // ------------------------------------------------------------------
  // FIFO storage (data array needs no reset)
  // ------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_awvalid     <= 1'b0;
      r_addr        <= '0;
      r_total       <= '0;
      r_issued      <= '0;
      r_accepted    <= '0;
      r_burst_beats <= '0;
      r_beat_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_push) begin
        r_accepted <= r_accepted + LEN_WIDTH'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (!r_busy) begin
            if (cfg_start) begin
              r_addr     <= cfg_base_addr & ~ALIGN_MASK;
              r_total    <= cfg_beats;
              r_issued   <= '0;
              r_accepted <= '0;
              r_error    <= 1'b0;
              r_busy     <= 1'b1;
              if (cfg_beats == '0) begin
                r_state <= S_DONE;
              end
            end
          end else if (w_burst_ready) begin
            r_burst_beats <= w_burst_beats;
            r_issued      <= r_issued + LEN_WIDTH'(w_burst_beats);
            r_awvalid     <= 1'b1;
            r_state       <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (m_axi_awready) begin
            r_awvalid  <= 1'b0;
            r_addr     <= r_addr + (ADDR_WIDTH'(r_burst_beats) << SIZE);
            r_beat_cnt <= '0;
            r_state    <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_pop) begin
            if (w_wlast) begin
              r_beat_cnt <= '0;
              r_state    <= S_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 5'd1;
            end
          end
        end

        S_RESP: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) begin
              r_error <= 1'b1;
            end
            r_state <= (r_issued == r_total) ? S_DONE : S_IDLE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign sts_busy      = r_busy;
  assign sts_done      = r_done;
  assign sts_error     = r_error;
  assign s_axis_tready = w_tready;

  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 4'(r_burst_beats - 5'd1);
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;

  assign m_axi_wdata   = r_mem[r_rd_ptr];
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = w_wvalid;
  assign m_axi_wlast   = w_wvalid & w_wlast;
  assign m_axi_bready  = (r_state == S_RESP);

endmodule

// File: tb/tb_axis_hp_writer.sv
// tb/tb_axis_hp_writer.sv - randomized self-checking bench for axis_hp_writer
module tb_axis_hp_writer;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BL = 16;
  localparam int FD = 32;
  localparam int LW = 24;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [LW-1:0] cfg_beats = '0;
  logic          sts_busy, sts_done, sts_error;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [AW-1:0] m_axi_awaddr;
  logic [3:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic [3:0]    m_axi_awcache;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;

  axis_hp_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
                   .FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_beats(cfg_beats),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_error(sts_error),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 aclk = ~aclk;

  int n_pass = 0;
  int n_total = 0;

  // Bus environment controls
  bit       wr_rand = 0, tv_rand = 0, aw_rand = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int       strm_left = 0;
  bit       tv_taken = 0;
  bit       bpend = 0;
  int       wbeat = 0;

  // Observation logs
  logic [63:0] sent_q[$];
  logic [31:0] aw_addr_q[$];
  logic [3:0]  aw_len_q[$];
  logic [63:0] w_data_q[$];
  bit          w_last_q[$];
  logic [63:0] ddr [logic [31:0]];
  int done_cnt = 0, b_cnt = 0, wl_cnt = 0, viol_out = 0, viol_early = 0;

  // Reference model output
  logic [31:0] m_addr_q[$];
  logic [3:0]  m_len_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // AXI slave, stream source and monitor. Inputs change at negedge; the
  // handshakes that will happen at the next posedge are logged 1 time unit later.
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        bpend = 0; wbeat = 0; tv_taken = 0;
        s_axis_tvalid = 1'b0; m_axi_bvalid = 1'b0;
        continue;
      end
      if (tv_taken) begin
        s_axis_tvalid = 1'b0;
        tv_taken = 0;
      end
      if (strm_left <= 0) s_axis_tvalid = 1'b0;
      m_axi_awready = aw_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      m_axi_wready  = wr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      m_axi_bvalid  = bpend;
      m_axi_bresp   = bpend ? bresp_cfg : 2'b00;
      if (!s_axis_tvalid && strm_left > 0 && (!tv_rand || $urandom_range(0, 1) == 1)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {$urandom, $urandom};
      end
      #1;
      if (!aresetn) continue;
      if (s_axis_tvalid && s_axis_tready) begin
        sent_q.push_back(s_axis_tdata);
        strm_left--;
        tv_taken = 1;
      end
      if (m_axi_wvalid && aw_addr_q.size() <= wl_cnt) viol_early++;
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_addr_q.size() != b_cnt) viol_out++;
        aw_addr_q.push_back(m_axi_awaddr);
        aw_len_q.push_back(m_axi_awlen);
        wbeat = 0;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        bpend = 0;
        b_cnt++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_data_q.push_back(m_axi_wdata);
        w_last_q.push_back(m_axi_wlast);
        if (wl_cnt < aw_addr_q.size())
          ddr[aw_addr_q[wl_cnt] + 32'(wbeat * 8)] = m_axi_wdata;
        wbeat++;
        if (m_axi_wlast) begin
          wl_cnt++;
          wbeat = 0;
          bpend = 1;
        end
      end
      if (sts_done) done_cnt++;
    end
  end

  task automatic clear_logs();
    sent_q.delete(); aw_addr_q.delete(); aw_len_q.delete();
    w_data_q.delete(); w_last_q.delete(); ddr.delete();
    done_cnt = 0; b_cnt = 0; wl_cnt = 0; viol_out = 0; viol_early = 0;
  endtask

  // Expected bursts: split the aligned range into chunks of at most BL beats
  // (and, with the 4K option, never crossing a 4096-byte page).
  task automatic model_bursts(input logic [31:0] base, input int beats, output logic [31:0] al);
    logic [31:0] a;
    int rem, n;
    m_addr_q.delete(); m_len_q.delete();
`ifdef AXIS_HP_WRITER_4K_SPLIT_EN
    a = base & ~32'h7;
`else
    a = base & ~32'(BL * 8 - 1);
`endif
    al = a;
    rem = beats;
    while (rem > 0) begin
      n = (rem < BL) ? rem : BL;
`ifdef AXIS_HP_WRITER_4K_SPLIT_EN
      if ((4096 - int'(a % 4096)) / 8 < n) n = (4096 - int'(a % 4096)) / 8;
`endif
      m_addr_q.push_back(a);
      m_len_q.push_back(4'(n - 1));
      a = a + 32'(n * 8);
      rem = rem - n;
    end
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] base, input int beats,
                          input int extra, input bit wrr, input bit tvr, input bit awr,
                          input logic [1:0] br, input bit exp_err, input bit poke);
    logic [31:0] al;
    int pos, k;
    bit exp_last;
    clear_logs();
    wr_rand = wrr; tv_rand = tvr; aw_rand = awr; bresp_cfg = br;
    strm_left = beats + extra;
    @(negedge aclk);
    cfg_base_addr = base; cfg_beats = LW'(beats); cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    #2;
    chk({tag, " busy_after_start"}, sts_busy, 1'b1);
    chk({tag, " error_cleared_on_start"}, sts_error, 1'b0);
    if (poke) begin
      repeat (3) @(negedge aclk);
      cfg_base_addr = 32'h0; cfg_beats = 24'd3; cfg_start = 1'b1;
      @(negedge aclk);
      cfg_start = 1'b0;
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      @(negedge aclk);
      #2;
    end
    chk({tag, " done_seen"}, 64'(done_cnt > 0), 64'd1);
    repeat (6) @(negedge aclk);
    #2;
    model_bursts(base, beats, al);
    chk({tag, " aw_count"}, 64'(aw_addr_q.size()), 64'(m_addr_q.size()));
    for (int i = 0; i < m_addr_q.size() && i < aw_addr_q.size(); i++) begin
      chk($sformatf("%s aw_addr[%0d]", tag, i), aw_addr_q[i], m_addr_q[i]);
      chk($sformatf("%s aw_len[%0d]", tag, i), aw_len_q[i], m_len_q[i]);
    end
    chk({tag, " accepted_beats"}, 64'(sent_q.size()), 64'(beats));
    chk({tag, " w_beats"}, 64'(w_data_q.size()), 64'(beats));
    for (k = 0; k < beats && k < sent_q.size(); k++)
      chk($sformatf("%s ddr[%0d]", tag, k),
          ddr.exists(al + 32'(k * 8)) ? ddr[al + 32'(k * 8)] : 64'hx, sent_q[k]);
    pos = 0;
    k = 0;
    for (int b = 0; b < m_len_q.size(); b++) begin
      for (int j = 0; j <= int'(m_len_q[b]); j++) begin
        exp_last = (j == int'(m_len_q[b]));
        if (k < w_last_q.size())
          chk($sformatf("%s wlast[%0d]", tag, k), w_last_q[k], exp_last);
        k++;
      end
    end
    chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, " busy_end"}, sts_busy, 1'b0);
    chk({tag, " error_end"}, sts_error, exp_err);
    chk({tag, " one_outstanding"}, 64'(viol_out), 64'd0);
    chk({tag, " w_before_aw"}, 64'(viol_early), 64'd0);
    strm_left = 0;
    @(negedge aclk);
  endtask

  initial begin
    logic [31:0] rb;
    int rn;

    // Reset state
    #12;
    chk("reset outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready,
                          sts_busy, sts_done, sts_error}, 7'd0);
    @(negedge aclk);
    #2 aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("const awburst", m_axi_awburst, 2'b01);
    chk("const awsize", m_axi_awsize, 3'd3);
    chk("const wstrb", m_axi_wstrb, 8'hFF);

    // Basic transfer
    run_xfer("basic", 32'h1000_0000, 32, 0, 0, 0, 0, 2'b00, 0, 0);
    chk("basic aw0", (aw_addr_q.size() > 0) ? aw_addr_q[0] : 32'hx, 32'h1000_0000);
    chk("basic aw1", (aw_addr_q.size() > 1) ? aw_addr_q[1] : 32'hx, 32'h1000_0080);

    // Short tail, back-pressure, random valid; also a start while busy
    run_xfer("tail", 32'h2000_0000, 20, 5, 1, 1, 0, 2'b00, 0, 1);
    chk("tail len1", (aw_len_q.size() > 1) ? aw_len_q[1] : 4'hx, 4'd3);

    // Error response, then a clean transfer clears the flag
    run_xfer("err", 32'h3000_0100, 16, 0, 0, 0, 0, 2'b10, 1, 0);
    run_xfer("after_err", 32'h3000_0200, 16, 0, 0, 0, 0, 2'b00, 0, 0);

    // Zero length
    clear_logs();
    @(negedge aclk);
    cfg_beats = '0; cfg_base_addr = 32'h4000_0000; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    #2;
    chk("zero done_early", sts_done, 1'b0);
    chk("zero busy", sts_busy, 1'b1);
    @(negedge aclk);
    #2;
    chk("zero done_pulse", sts_done, 1'b1);
    chk("zero busy_fall", sts_busy, 1'b0);
    @(negedge aclk);
    #2;
    chk("zero done_one_cycle", sts_done, 1'b0);
    chk("zero no_aw", 64'(aw_addr_q.size()), 64'd0);

`ifdef AXIS_HP_WRITER_4K_SPLIT_EN
    run_xfer("split4k", 32'h0000_0FC0, 16, 0, 0, 0, 0, 2'b00, 0, 0);
    chk("split4k aw1", (aw_addr_q.size() > 1) ? aw_addr_q[1] : 32'hx, 32'h0000_1000);
    chk("split4k len0", (aw_len_q.size() > 0) ? aw_len_q[0] : 4'hx, 4'd7);
`endif

    // Randomized transfers
    for (int t = 0; t < 4; t++) begin
      rb = $urandom;
      rn = $urandom_range(1, 45);
      run_xfer($sformatf("rand%0d", t), rb, rn, $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 2'b00, 0, 0);
    end

    // Reset mid-burst
    clear_logs();
    wr_rand = 0; tv_rand = 0; aw_rand = 0; bresp_cfg = 2'b00;
    strm_left = 40;
    @(negedge aclk);
    cfg_base_addr = 32'h5000_0000; cfg_beats = 24'd32; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    for (int i = 0; i < 2000 && w_data_q.size() < 5; i++) begin
      @(negedge aclk);
      #2;
    end
    chk("midrst reached_beat5", 64'(w_data_q.size() >= 5), 64'd1);
    aresetn = 1'b0;
    strm_left = 0;
    #1;
    chk("midrst outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready,
                           sts_busy, sts_done, sts_error}, 7'd0);
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    run_xfer("post_rst", 32'h5000_1000, 16, 0, 0, 0, 0, 2'b00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
